// File: rtl/spart_pkg.sv
// Shared constants, FSM encodings and the tick reload helper for the SPART slice.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Divisors of 0 and 1 both collapse to a tick on every cycle.
    function automatic logic [15:0] tick_reload(input logic [15:0] d);
        return (d < 16'd2) ? 16'd0 : d - 16'd1;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Divisor registers and 16x tick down-counter; tick is one cycle every div cycles.
// Divisor writes take effect on the next cycle and restart the count; no backpressure.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wr_dat,
    output logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;
    logic [15:0] div_nxt;

    always_comb begin
        div_nxt = div;
        if (wr_lo) div_nxt[7:0]  = wr_dat;
        if (wr_hi) div_nxt[15:8] = wr_dat;
    end

    assign tick = (cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= DEFAULT_DIV;
            cnt <= tick_reload(DEFAULT_DIV);
        end else begin
            div <= div_nxt;
            if (wr_lo || wr_hi || tick) cnt <= tick_reload(div_nxt);
            else                        cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/spart.sv
// SPART bus responder: register decode, 16x-oversampled 8N1 TX and RX.
// Reads are combinational, writes land on the clock edge; TX writes are dropped while tbr is low.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  logic [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        rd_sel, wr_sel, tx_accept, rd_buf;
    logic [7:0]  rd_dat;
    logic [15:0] div;
    logic        tick;

    tx_state_t   tx_state;
    logic [7:0]  tx_shift;
    logic [3:0]  tx_tcnt;
    logic [2:0]  tx_bit;

    rx_state_t   rx_state;
    logic        rx_s1, rx_s2;
    logic [7:0]  rx_shift, rx_buf;
    logic [3:0]  rx_tcnt;
    logic [2:0]  rx_bit;
    logic        rx_err;

    assign rd_sel    = iocs & iorw;
    assign wr_sel    = iocs & ~iorw;
    assign rd_buf    = rd_sel && (ioaddr == ADDR_BUF);
    assign tx_accept = wr_sel && (ioaddr == ADDR_BUF) && tbr;

    spart_baud_gen #(.DEFAULT_DIV(DEFAULT_DIV)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .wr_lo  (wr_sel && (ioaddr == ADDR_DBL)),
        .wr_hi  (wr_sel && (ioaddr == ADDR_DBH)),
        .wr_dat (databus),
        .div    (div),
        .tick   (tick)
    );

    always_comb begin
        rd_dat = 8'h00;
        case (ioaddr)
            ADDR_BUF:  rd_dat = rx_buf;
            ADDR_STAT: rd_dat = {6'b0, rda, tbr};
            ADDR_DBL:  rd_dat = div[7:0];
            ADDR_DBH:  rd_dat = div[15:8];
            default:   rd_dat = 8'h00;
        endcase
    end

    assign databus = rd_sel ? rd_dat : 8'hzz;

    // In START, txd still high means we are waiting for the first tick to drop it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tbr      <= 1'b1;
            txd      <= 1'b1;
            tx_shift <= 8'h00;
            tx_tcnt  <= 4'd0;
            tx_bit   <= 3'd0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_shift <= databus;
                        tbr      <= 1'b0;
                        tx_tcnt  <= 4'd0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (txd) begin
                            txd <= 1'b0;
                        end else begin
                            tx_tcnt <= tx_tcnt + 4'd1;
                            if (tx_tcnt == LAST_TICK) begin
                                txd      <= tx_shift[0];
                                tx_shift <= tx_shift >> 1;
                                tx_bit   <= 3'd0;
                                tx_state <= TX_DATA;
                            end
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        tx_tcnt <= tx_tcnt + 4'd1;
                        if (tx_tcnt == LAST_TICK) begin
                            if (tx_bit == 3'd7) begin
                                txd      <= 1'b1;
                                tx_state <= TX_STOP;
                            end else begin
                                txd      <= tx_shift[0];
                                tx_shift <= tx_shift >> 1;
                                tx_bit   <= tx_bit + 3'd1;
                            end
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        tx_tcnt <= tx_tcnt + 4'd1;
                        if (tx_tcnt == LAST_TICK) begin
                            tbr      <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // The completion set is assigned after the read clear so a new byte keeps rda high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_shift <= 8'h00;
            rx_buf   <= 8'h00;
            rx_tcnt  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_err   <= 1'b0;
            rda      <= 1'b0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            if (rd_buf) rda <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_tcnt  <= 4'd0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == MID_TICK) begin
                            rx_tcnt  <= 4'd0;
                            rx_bit   <= 3'd0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == LAST_TICK) begin
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_err) begin
                        if (rx_s2) begin
                            rx_err   <= 1'b0;
                            rx_state <= RX_IDLE;
                        end
                    end else if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == LAST_TICK) begin
                            if (rx_s2) begin
                                rx_buf   <= rx_shift;
                                rda      <= 1'b1;
                                rx_state <= RX_IDLE;
                            end else begin
                                rx_err <= 1'b1;
                            end
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart.sv
// Directed bench for spart: register table, TX frame timing, RX frames and reset abort.
module tb_spart;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dat = 8'h00;
    logic       rxd = 1'b1;
    logic       rda, tbr, txd;
    wire  [7:0] databus;

    int checks = 0;
    int errors = 0;

    assign databus = tb_oe ? tb_dat : 8'hzz;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dat = d; tb_oe = 1'b1;
        @(negedge clk);
        iocs = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    // One 8N1 frame at div=4: 64 clocks per bit, followed by idle line.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (64) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [9:0] tx_exp;
        logic       found;

        vt[0] = '{1'b0, 2'b01, 8'h00, 8'h01};
        vt[1] = '{1'b0, 2'b10, 8'h00, 8'h45};
        vt[2] = '{1'b0, 2'b11, 8'h00, 8'h01};
        vt[3] = '{1'b0, 2'b00, 8'h00, 8'h00};
        vt[4] = '{1'b1, 2'b10, 8'h04, 8'h00};
        vt[5] = '{1'b1, 2'b11, 8'h00, 8'h00};
        vt[6] = '{1'b0, 2'b10, 8'h00, 8'h04};
        vt[7] = '{1'b0, 2'b11, 8'h00, 8'h00};
        vt[8] = '{1'b1, 2'b01, 8'hFF, 8'h00};
        vt[9] = '{1'b0, 2'b01, 8'h00, 8'h01};

        repeat (3) @(negedge clk);
        chk("reset_tbr", tbr, 1);
        chk("reset_rda", rda, 0);
        chk("reset_txd", txd, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bus must be free when not selected: the bench's own drive reads back intact.
        iorw = 1'b1; tb_dat = 8'h5A; tb_oe = 1'b1;
        #1 chk("bus_released", databus, 8'h5A);
        tb_oe = 1'b0; iorw = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vt[i].wr) begin
                bus_write(vt[i].addr, vt[i].dat);
            end else begin
                bus_read(vt[i].addr, rd);
                chk($sformatf("reg_vec%0d", i), rd, vt[i].exp);
            end
        end

        // TX 0xA5 at div=4
        tx_exp = {1'b1, 8'hA5, 1'b0};
        bus_write(2'b00, 8'hA5);
        chk("tx_tbr_fall", tbr, 0);
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            @(negedge clk);
            if (txd == 1'b0) found = 1'b1;
        end
        chk("tx_start_seen", found, 1);
        if (found) begin
            for (int k = 0; k <= 640; k++) begin
                if (k % 64 == 0 && k < 640)
                    chk($sformatf("tx_bit%0d_begin", k / 64), txd, tx_exp[k / 64]);
                if (k % 64 == 63)
                    chk($sformatf("tx_bit%0d_end", k / 64), txd, tx_exp[k / 64]);
                if (k == 100) begin
                    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; tb_dat = 8'hFF; tb_oe = 1'b1;
                end
                if (k == 101) begin
                    iocs = 1'b0; tb_oe = 1'b0;
                end
                if (k == 639) chk("tx_tbr_busy_end", tbr, 0);
                if (k == 640) begin
                    chk("tx_tbr_rise", tbr, 1);
                    chk("tx_idle_txd", txd, 1);
                end
                if (k < 640) @(negedge clk);
            end
        end
        repeat (300) @(negedge clk);
        chk("tx_no_second_frame", txd, 1);

        // RX 0x3C
        send_frame(8'h3C, 1'b1);
        chk("rx_rda_set", rda, 1);
        bus_read(2'b00, rd);
        chk("rx_byte_3c", rd, 8'h3C);
        chk("rx_rda_clear", rda, 0);

        // 3-tick glitch
        @(negedge clk);
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        repeat (700) @(negedge clk);
        chk("rx_glitch_no_rda", rda, 0);

        // Framing error
        send_frame(8'h55, 1'b0);
        chk("rx_frame_err_rda", rda, 0);
        bus_read(2'b00, rd);
        chk("rx_frame_err_buf", rd, 8'h3C);

        // Overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("rx_overrun_rda", rda, 1);
        bus_read(2'b00, rd);
        chk("rx_overrun_byte", rd, 8'h22);
        chk("rx_overrun_clear", rda, 0);

        // Reset mid-frame
        bus_write(2'b00, 8'h5A);
        repeat (100) @(negedge clk);
        chk("rst_tx_busy", tbr, 0);
        chk("rst_tx_low", txd, 0);
        rst = 1'b1;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_tbr", tbr, 1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'b10, rd);
        chk("rst_div_lo", rd, 8'h45);
        bus_read(2'b11, rd);
        chk("rst_div_hi", rd, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
